vga_scan_gen: RTL
=================

# vga_scan_gen

Raster scan generator for the 640x480@60 Hz display path. It produces the current pixel coordinate (`curr_x`, `curr_y`) consumed by every object hit-test in the renderer, plus VGA sync, the active-video qualifier and a once-per-frame tick. Note-position update logic uses that tick to move notes while the screen is in vertical blanking.

## Interface
Parameters:
- `CLK_DIV`, 2: system clocks per pixel; must be at least 1.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.

Ports:
- `clk`  in  1: system clock. One clock domain. Reset is asynchronous and active-low.
- `rst_n`  in  1: asynchronous active-low reset. Clears all state.
- `curr_x`  out  10: current column. 0..H_ACTIVE-1 while `video_on`, 0 otherwise.
- `curr_y`  out  9: current row. 0..V_ACTIVE-1 while `video_on`, 0 otherwise.
- `video_on`  out  1: high while the counters are inside the active window.
- `hsync`  out  1: horizontal sync, active-low.
- `vsync`  out  1: vertical sync, active-low.
- `pix_tick`  out  1: one-`clk` pixel strobe.
- `frame_tick`  out  1: one-`clk` pulse at the start of vertical blanking.
- `frame_count`  out  8: completed-frame counter; wraps from 255 to 0.

## Operation
- Derived totals: H_TOTAL = sum of the H params (800); V_TOTAL = sum of the V params (525).
- Registers:
  - `div`: 0..CLK_DIV-1, increments every `clk`, wraps to 0.
  - `h_cnt`: 10 bits, 0..H_TOTAL-1.
  - `v_cnt`: 10 bits, 0..V_TOTAL-1.
  - `frame_count`: 8 bits.
- `pix_tick = (div == CLK_DIV-1)`. When CLK_DIV = 1, `pix_tick` is held at 1.
- Counter stepping, on `clk` edges where `pix_tick` is 1:
  - `h_cnt` increments.
  - At H_TOTAL-1, `h_cnt` wraps to 0 and `v_cnt` increments.
  - At (H_TOTAL-1, V_TOTAL-1), both counters wrap to 0.
- `frame_count` increments on the same edge that moves `v_cnt` from V_ACTIVE-1 to V_ACTIVE.
- `video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)`.
- `curr_x` / `curr_y`:
  - Equal `h_cnt[9:0]` / `v_cnt[8:0]` when `video_on` is 1.
  - Forced to 0 when `video_on` is 0.
  - V_ACTIVE must be 512 or less so `curr_y` fits in 9 bits.
- `hsync` is 0 iff H_ACTIVE+H_FP ≤ `h_cnt` < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
- `vsync` is 0 iff V_ACTIVE+V_FP ≤ `v_cnt` < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
- `frame_tick = (h_cnt == 0) && (v_cnt == V_ACTIVE) && (div == 0)`. This gives exactly one `clk` per frame.
- Every output is decoded from the current register values. No output has additional latency relative to the counters.

## Timing
- Reset (asynchronous, `rst_n` low):
  - `div`, `h_cnt`, `v_cnt` and `frame_count` are 0.
  - Resulting outputs: `curr_x` = 0, `curr_y` = 0, `video_on` = 1, `hsync` = 1, `vsync` = 1, `frame_tick` = 0, `frame_count` = 0.
  - `pix_tick` is 0 when CLK_DIV > 1 and 1 when CLK_DIV = 1.
- First rising `clk` edge after `rst_n` deasserts: `div` advances. Pixel (0,0) is presented for CLK_DIV clocks starting at reset release.
- Each pixel coordinate is stable for exactly CLK_DIV clocks.
- Line length is H_TOTAL × CLK_DIV clocks. Frame length is H_TOTAL × V_TOTAL × CLK_DIV clocks (840000 at defaults).
- Reset asserted mid-line or mid-frame: all registers clear immediately. The scan restarts at (0,0) with no partial `frame_tick`.
- Hsync is generated on every line, including vertical-blanking lines.
- The frame boundary (both counters wrapping) does not generate `frame_tick`. Only the active-to-blank transition does.

## Test plan
- Reset with CLK_DIV = 2, hold 10 clocks, then release. Required: during reset, outputs hold their reset values. After release, `curr_x` steps 0,0,1,1,2,2,… with `pix_tick` high on odd clocks.
- Run one line. Required:
  - `video_on` falls when `h_cnt` reaches 640 (`clk` 1280 after release).
  - `hsync` is low for exactly 192 clocks, starting at `h_cnt` = 656.
  - `curr_x` is 0 throughout blanking.
- Run one full frame. Required:
  - `vsync` is low for exactly 2 lines (lines 490–491, 3200 clocks).
  - `frame_tick` pulses once, at `clk` 768000 after release.
  - `frame_count` reads 1 afterwards.
  - The counters return to (0,0) at `clk` 840000.
- Run 256 frames with CLK_DIV = 1. Required: `frame_count` wraps 255 → 0, and exactly 256 `frame_tick` pulses are seen.
- Assert `rst_n` low at (`h_cnt`, `v_cnt`) = (700, 300) for 1 clock. Required: outputs return to their reset values asynchronously, and the next frame's `frame_tick` appears 768000 clocks after release.
- Scoreboard check across a full frame: `curr_x` stays < 640 and `curr_y` stays < 480 whenever `video_on` is 1.

Source files
------------

// File: rtl/vga_scan_if.sv
// Raster-scan output bundle: pixel coordinate, sync, active-video qualifier
// and the per-pixel / per-frame strobes.
// The generator drives the bundle through the master modport. Consumers read it
// through the slave modport.
// There is no handshake on this bundle. Every signal is valid on every clock,
// and consumers sample it on the same clock edge that advances the scan.
interface vga_scan_if;
  logic [9:0] curr_x;
  logic [8:0] curr_y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       pix_tick;
  logic       frame_tick;
  logic [7:0] frame_count;

  modport master (
    output curr_x, curr_y, video_on, hsync, vsync, pix_tick, frame_tick, frame_count
  );

  modport slave (
    input curr_x, curr_y, video_on, hsync, vsync, pix_tick, frame_tick, frame_count
  );
endinterface

// File: rtl/vga_scan_gen.sv
// Raster scan generator for the VGA display path.
// A clock divider produces the pixel strobe. The horizontal and vertical
// counters walk the full raster, including the blanking intervals.
// All outputs are decoded combinationally from the counter registers, so no
// output lags the counters.
module vga_scan_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  vga_scan_if.master vga
);

  // A one-bit divider is kept when CLK_DIV = 1. It then never leaves 0,
  // which holds pix_tick high.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic [7:0]       frame_cnt;
  logic             pix_tick;
  logic             video_on;
  logic             h_wrap;
  logic             v_wrap;

  assign pix_tick = (div == DIV_MAX);
  assign h_wrap   = (h_cnt == H_LAST);
  assign v_wrap   = (v_cnt == V_LAST);
  assign video_on = (h_cnt < H_ACT) && (v_cnt < V_ACT);

  // Divider: one pixel every CLK_DIV system clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (pix_tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Raster counters step once per pixel strobe. Both wrap together at the
  // bottom-right corner of the raster.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Completed-frame counter: bumps when the last active line finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (pix_tick && h_wrap && (v_cnt == V_ACT_LAST)) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  assign vga.pix_tick    = pix_tick;
  assign vga.video_on    = video_on;
  assign vga.curr_x      = video_on ? h_cnt : 10'd0;
  assign vga.curr_y      = video_on ? v_cnt[8:0] : 9'd0;
  assign vga.hsync       = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vga.vsync       = !((v_cnt >= VS_START) && (v_cnt < VS_END));
  // Qualified by div == 0 so that the pulse lasts one clock, not one pixel.
  assign vga.frame_tick  = (h_cnt == 10'd0) && (v_cnt == V_ACT) && (div == '0);
  assign vga.frame_count = frame_cnt;

endmodule
